vending_machine_param: RTL and testbench
========================================

Name: vending_machine_param

Overview:
- Parametrised successor to the fixed 4-product vending controller.
- Generalised product count and stock, with:
  - per-product stock tracking and sold-out signalling
  - a coin-reject path
  - cancel/refund
  - inactivity timeout refund
  - exact change computed arithmetically
- Sits between the coin acceptor/keypad front end and the dispense/change actuators.

Parameters:
- NUM_PRODUCTS, 4: number of products; product i price = PRICE_STEP*(i+1).
- SEL_W, 2: selection width; 2**SEL_W >= NUM_PRODUCTS.
- CREDIT_W, 6: width of credit and change datapath.
- PRICE_STEP, 5: price increment in rupees.
- MAX_CREDIT, 40: credit ceiling; must be >= top price and < 2**CREDIT_W.
- STOCK_W, 4: per-product stock counter width.
- INIT_STOCK, 3: stock loaded at reset/restock; must be < 2**STOCK_W.
- TIMEOUT, 16: idle cycles in COLLECT before automatic refund.

Ports:
- clk  in  1  single clock; all logic on posedge.
- reset  in  1  synchronous, active-high.
- coin_valid  in  1  one-cycle strobe; coin_in is valid.
- coin_in  in  CREDIT_W  coin value; only 5, 10, 20 accepted.
- sel_valid  in  1  one-cycle strobe; selection is valid.
- selection  in  SEL_W  product index.
- cancel  in  1  request refund of current credit.
- restock  in  1  reload stock of product `selection` to INIT_STOCK.
- product_valid  out  1  one-cycle dispense pulse.
- product_out  out  SEL_W  index of dispensed product.
- change_valid  out  1  one-cycle change/refund pulse.
- coin_out  out  CREDIT_W  change or refund amount.
- coin_reject  out  1  one-cycle pulse: offered coin returned.
- sold_out  out  1  one-cycle pulse: selected product has zero stock.
- credit  out  CREDIT_W  current accumulated credit (registered).

Behaviour:
Reset (synchronous):
- state=IDLE; credit=0; pending selection cleared; timeout counter=0.
- All outputs 0; every stock[i]=INIT_STOCK.
- Reset mid-transaction discards credit with no refund pulse.

Pulse outputs:
- product_valid, change_valid, coin_reject and sold_out are registered.
- Each defaults to 0 every cycle unless set below.

States IDLE, COLLECT, VEND, REFUND:
- IDLE:
  - Accepted coin -> credit=coin, go to COLLECT.
  - sel_valid -> latch pending selection and go to COLLECT; credit stays 0.
  - restock -> stock[selection]=INIT_STOCK. restock is ignored in all other states.
- COLLECT, priority order per cycle:
  1. cancel: go to REFUND; a coin offered the same cycle is rejected.
  2. Timeout: counter reaches TIMEOUT-1 with no coin_valid/sel_valid that cycle -> REFUND. The counter clears on any coin_valid or sel_valid.
  3. Coin:
     - coin_in is 5/10/20 and credit+coin_in <= MAX_CREDIT -> credit += coin_in.
     - Otherwise coin_reject=1 and credit is unchanged.
  4. sel_valid with selection < NUM_PRODUCTS:
     - stock>0 -> latch pending selection, replacing any earlier one.
     - stock==0 -> sold_out=1 and pending cleared.
     - selection >= NUM_PRODUCTS -> ignored.
  5. Vend check on registered values: pending valid and credit >= price(pending) -> VEND next cycle.
  - A coin and sel_valid in the same cycle are both processed.
- VEND, single cycle:
  - product_valid=1, product_out=pending.
  - change_valid=1 only if credit > price; coin_out = credit - price.
  - stock[pending] -= 1; credit=0; pending cleared; go to IDLE.
- REFUND, single cycle:
  - change_valid=1 and coin_out=credit if credit > 0.
  - credit=0; pending cleared; go to IDLE.
- Coins offered in VEND or REFUND -> coin_reject=1.

Latency and arithmetic:
- Latency: sel_valid sampled at edge N with credit already sufficient -> product_valid asserted after edge N+2 for exactly one cycle.
- Credit never exceeds MAX_CREDIT.
- Subtraction never underflows.
- Stock never decrements below 0.

Test Plan:
- Reset, coin 5, select product 0 (price 5) -> product_valid pulse, product_out=0, no change_valid, credit returns 0.
- Select product 3 (price 20); coins 10, 5, 10 -> credit 25, product_valid with product_out=3, change_valid with coin_out=5.
- Coin 7, then coin 20 twice, then 5 (MAX_CREDIT=40) -> coin_reject on the 7 and on the final 5; credit=40.
- Coin 10 then cancel -> change_valid with coin_out=10, no product_valid. Separately, coin 5 then TIMEOUT idle cycles -> refund of 5.
- Buy product 1 INIT_STOCK times, then select 1 again -> sold_out pulse, no vend. restock with selection=1 in IDLE, then buy -> vend succeeds.
- Coin 10, assert reset mid-COLLECT -> all outputs 0, credit 0, no refund pulse, stock back to INIT_STOCK.

Source files
------------

// File: rtl/vending_machine_param_if.sv
// Front-end to controller bundle: coin/keypad requests in, dispense/change actuator pulses out.
interface vending_machine_param_if #(
  parameter int unsigned SEL_W    = 2,
  parameter int unsigned CREDIT_W = 6
);
  logic                coin_valid;
  logic [CREDIT_W-1:0] coin_in;
  logic                sel_valid;
  logic [SEL_W-1:0]    selection;
  logic                cancel;
  logic                restock;
  logic                product_valid;
  logic [SEL_W-1:0]    product_out;
  logic                change_valid;
  logic [CREDIT_W-1:0] coin_out;
  logic                coin_reject;
  logic                sold_out;
  logic [CREDIT_W-1:0] credit;

  modport master (
    output coin_valid, coin_in, sel_valid, selection, cancel, restock,
    input  product_valid, product_out, change_valid, coin_out, coin_reject, sold_out, credit
  );

  modport slave (
    input  coin_valid, coin_in, sel_valid, selection, cancel, restock,
    output product_valid, product_out, change_valid, coin_out, coin_reject, sold_out, credit
  );
endinterface

// File: rtl/vending_machine_param.sv
// Parametrised vending controller: credit collection, per-product stock, vend with change,
// cancel and inactivity-timeout refunds. All outputs registered.
module vending_machine_param #(
  parameter int unsigned NUM_PRODUCTS = 4,
  parameter int unsigned SEL_W        = 2,
  parameter int unsigned CREDIT_W     = 6,
  parameter int unsigned PRICE_STEP   = 5,
  parameter int unsigned MAX_CREDIT   = 40,
  parameter int unsigned STOCK_W      = 4,
  parameter int unsigned INIT_STOCK   = 3,
  parameter int unsigned TIMEOUT      = 16
) (
  input logic                   clk,
  input logic                   reset,
  vending_machine_param_if.slave bus
);
  localparam int unsigned TimerW = $clog2(TIMEOUT) + 1;

  typedef enum logic [1:0] {StIdle, StCollect, StVend, StRefund} state_e;

  state_e              state_q, state_d;
  logic [CREDIT_W-1:0] credit_q, credit_d;
  logic                pend_valid_q, pend_valid_d;
  logic [SEL_W-1:0]    pend_sel_q, pend_sel_d;
  logic [TimerW-1:0]   timer_q, timer_d;
  logic [STOCK_W-1:0]  stock_q [NUM_PRODUCTS];
  logic [STOCK_W-1:0]  stock_d [NUM_PRODUCTS];
  logic                product_valid_q, product_valid_d;
  logic [SEL_W-1:0]    product_out_q, product_out_d;
  logic                change_valid_q, change_valid_d;
  logic [CREDIT_W-1:0] coin_out_q, coin_out_d;
  logic                coin_reject_q, coin_reject_d;
  logic                sold_out_q, sold_out_d;

  logic [CREDIT_W:0]   credit_sum;
  logic                coin_ok;
  logic                sel_in_range;
  logic [STOCK_W-1:0]  sel_stock;
  logic [CREDIT_W-1:0] pend_price;

  function automatic logic [CREDIT_W-1:0] price_of(logic [SEL_W-1:0] s);
    return CREDIT_W'(PRICE_STEP * (32'(s) + 32'd1));
  endfunction

  always_comb begin
    credit_sum   = {1'b0, credit_q} + {1'b0, bus.coin_in};
    coin_ok      = (bus.coin_in == CREDIT_W'(5) || bus.coin_in == CREDIT_W'(10) ||
                    bus.coin_in == CREDIT_W'(20)) && (credit_sum <= (CREDIT_W + 1)'(MAX_CREDIT));
    sel_in_range = 32'(bus.selection) < NUM_PRODUCTS;
    pend_price   = price_of(pend_sel_q);
    sel_stock    = '0;
    for (int i = 0; i < NUM_PRODUCTS; i++) begin
      if (bus.selection == SEL_W'(i)) sel_stock = stock_q[i];
    end
  end

  always_comb begin
    state_d         = state_q;
    credit_d        = credit_q;
    pend_valid_d    = pend_valid_q;
    pend_sel_d      = pend_sel_q;
    timer_d         = timer_q;
    stock_d         = stock_q;
    product_valid_d = 1'b0;
    product_out_d   = '0;
    change_valid_d  = 1'b0;
    coin_out_d      = '0;
    coin_reject_d   = 1'b0;
    sold_out_d      = 1'b0;

    unique case (state_q)
      StIdle: begin
        timer_d = '0;
        if (bus.coin_valid) begin
          if (coin_ok) begin
            credit_d = bus.coin_in;
            state_d  = StCollect;
          end else begin
            coin_reject_d = 1'b1;
          end
        end
        if (bus.sel_valid && sel_in_range) begin
          state_d = StCollect;
          if (sel_stock != '0) begin
            pend_valid_d = 1'b1;
            pend_sel_d   = bus.selection;
          end else begin
            sold_out_d   = 1'b1;
            pend_valid_d = 1'b0;
          end
        end
        if (bus.restock) begin
          for (int i = 0; i < NUM_PRODUCTS; i++) begin
            if (bus.selection == SEL_W'(i)) stock_d[i] = STOCK_W'(INIT_STOCK);
          end
        end
      end

      StCollect: begin
        if (bus.cancel) begin
          state_d       = StRefund;
          coin_reject_d = bus.coin_valid;
        end else if (timer_q == TimerW'(TIMEOUT - 1) && !bus.coin_valid && !bus.sel_valid) begin
          state_d = StRefund;
        end else begin
          timer_d = (bus.coin_valid || bus.sel_valid) ? '0 : timer_q + TimerW'(1);
          if (bus.coin_valid) begin
            if (coin_ok) credit_d = credit_sum[CREDIT_W-1:0];
            else         coin_reject_d = 1'b1;
          end
          if (bus.sel_valid && sel_in_range) begin
            if (sel_stock != '0) begin
              pend_valid_d = 1'b1;
              pend_sel_d   = bus.selection;
            end else begin
              sold_out_d   = 1'b1;
              pend_valid_d = 1'b0;
            end
          end
          // Defer the vend while the pending selection is being replaced so VEND never
          // prices a product against credit that was only checked for the old one.
          if (pend_valid_q && credit_q >= pend_price && !(bus.sel_valid && sel_in_range)) begin
            state_d = StVend;
          end
        end
      end

      StVend: begin
        product_valid_d = 1'b1;
        product_out_d   = pend_sel_q;
        if (credit_q > pend_price) begin
          change_valid_d = 1'b1;
          coin_out_d     = credit_q - pend_price;
        end
        for (int i = 0; i < NUM_PRODUCTS; i++) begin
          if (pend_sel_q == SEL_W'(i) && stock_q[i] != '0) stock_d[i] = stock_q[i] - STOCK_W'(1);
        end
        coin_reject_d = bus.coin_valid;
        credit_d      = '0;
        pend_valid_d  = 1'b0;
        timer_d       = '0;
        state_d       = StIdle;
      end

      StRefund: begin
        if (credit_q != '0) begin
          change_valid_d = 1'b1;
          coin_out_d     = credit_q;
        end
        coin_reject_d = bus.coin_valid;
        credit_d      = '0;
        pend_valid_d  = 1'b0;
        timer_d       = '0;
        state_d       = StIdle;
      end

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q         <= StIdle;
      credit_q        <= '0;
      pend_valid_q    <= 1'b0;
      pend_sel_q      <= '0;
      timer_q         <= '0;
      product_valid_q <= 1'b0;
      product_out_q   <= '0;
      change_valid_q  <= 1'b0;
      coin_out_q      <= '0;
      coin_reject_q   <= 1'b0;
      sold_out_q      <= 1'b0;
      for (int i = 0; i < NUM_PRODUCTS; i++) stock_q[i] <= STOCK_W'(INIT_STOCK);
    end else begin
      state_q         <= state_d;
      credit_q        <= credit_d;
      pend_valid_q    <= pend_valid_d;
      pend_sel_q      <= pend_sel_d;
      timer_q         <= timer_d;
      product_valid_q <= product_valid_d;
      product_out_q   <= product_out_d;
      change_valid_q  <= change_valid_d;
      coin_out_q      <= coin_out_d;
      coin_reject_q   <= coin_reject_d;
      sold_out_q      <= sold_out_d;
      stock_q         <= stock_d;
    end
  end

  assign bus.product_valid = product_valid_q;
  assign bus.product_out   = product_out_q;
  assign bus.change_valid  = change_valid_q;
  assign bus.coin_out      = coin_out_q;
  assign bus.coin_reject   = coin_reject_q;
  assign bus.sold_out      = sold_out_q;
  assign bus.credit        = credit_q;
endmodule

// File: tb/tb_vending_machine_param.sv
// Directed bench for vending_machine_param with default parameters (prices 5/10/15/20).
module tb_vending_machine_param;
  logic clk;
  logic reset;
  int   checks;
  int   errors;

  vending_machine_param_if #(.SEL_W(2), .CREDIT_W(6)) bus ();

  vending_machine_param dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Outputs are read 1 time unit after the edge that registered them.
  task automatic tick();
    @(posedge clk);
    #1;
    bus.coin_valid = 1'b0;
    bus.sel_valid  = 1'b0;
    bus.cancel     = 1'b0;
    bus.restock    = 1'b0;
  endtask

  task automatic coin(input int v);
    bus.coin_valid = 1'b1;
    bus.coin_in    = 6'(v);
    tick();
  endtask

  task automatic sel(input int s);
    bus.sel_valid = 1'b1;
    bus.selection = 2'(s);
    tick();
  endtask

  // Coin then select; returns the outputs seen after the vend edge (select edge + 2).
  task automatic buy(input int s, input int v, output logic pv, output logic [1:0] po,
                     output logic cv, output logic [5:0] co);
    coin(v);
    sel(s);
    tick();
    tick();
    pv = bus.product_valid;
    po = bus.product_out;
    cv = bus.change_valid;
    co = bus.coin_out;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    checks++;
    if ({bus.product_valid, bus.change_valid, bus.coin_reject, bus.sold_out} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_pulses: got %b expected 0000",
               {bus.product_valid, bus.change_valid, bus.coin_reject, bus.sold_out});
    end
    checks++;
    if (bus.credit !== 6'd0) begin
      errors++;
      $display("FAIL reset_credit: got %0d expected 0", bus.credit);
    end
  endtask

  task automatic test_simple_vend();
    coin(5);
    sel(0);
    checks++;
    if (bus.credit !== 6'd5) begin
      errors++;
      $display("FAIL simple_credit: got %0d expected 5", bus.credit);
    end
    tick();
    checks++;
    if (bus.product_valid !== 1'b0) begin
      errors++;
      $display("FAIL simple_early: product_valid got %b expected 0", bus.product_valid);
    end
    tick();
    checks++;
    if (bus.product_valid !== 1'b1 || bus.product_out !== 2'd0 || bus.change_valid !== 1'b0) begin
      errors++;
      $display("FAIL simple_vend: pv/po/cv got %b/%0d/%b expected 1/0/0",
               bus.product_valid, bus.product_out, bus.change_valid);
    end
    checks++;
    if (bus.credit !== 6'd0) begin
      errors++;
      $display("FAIL simple_credit_clear: got %0d expected 0", bus.credit);
    end
    tick();
    checks++;
    if (bus.product_valid !== 1'b0) begin
      errors++;
      $display("FAIL simple_one_pulse: product_valid got %b expected 0", bus.product_valid);
    end
  endtask

  task automatic test_change();
    sel(3);
    coin(10);
    coin(5);
    coin(10);
    checks++;
    if (bus.credit !== 6'd25) begin
      errors++;
      $display("FAIL change_credit: got %0d expected 25", bus.credit);
    end
    tick();
    tick();
    checks++;
    if (bus.product_valid !== 1'b1 || bus.product_out !== 2'd3 ||
        bus.change_valid !== 1'b1 || bus.coin_out !== 6'd5) begin
      errors++;
      $display("FAIL change_vend: pv/po/cv/co got %b/%0d/%b/%0d expected 1/3/1/5",
               bus.product_valid, bus.product_out, bus.change_valid, bus.coin_out);
    end
    tick();
  endtask

  task automatic test_coin_reject();
    coin(7);
    checks++;
    if (bus.coin_reject !== 1'b1 || bus.credit !== 6'd0) begin
      errors++;
      $display("FAIL reject_7: reject/credit got %b/%0d expected 1/0", bus.coin_reject, bus.credit);
    end
    coin(20);
    coin(20);
    checks++;
    if (bus.coin_reject !== 1'b0 || bus.credit !== 6'd40) begin
      errors++;
      $display("FAIL max_credit: reject/credit got %b/%0d expected 0/40",
               bus.coin_reject, bus.credit);
    end
    coin(5);
    checks++;
    if (bus.coin_reject !== 1'b1 || bus.credit !== 6'd40) begin
      errors++;
      $display("FAIL reject_over: reject/credit got %b/%0d expected 1/40",
               bus.coin_reject, bus.credit);
    end
    bus.cancel = 1'b1;
    tick();
    tick();
    checks++;
    if (bus.change_valid !== 1'b1 || bus.coin_out !== 6'd40) begin
      errors++;
      $display("FAIL refund_40: cv/co got %b/%0d expected 1/40", bus.change_valid, bus.coin_out);
    end
  endtask

  task automatic test_cancel();
    coin(10);
    bus.cancel = 1'b1;
    bus.coin_valid = 1'b1;
    bus.coin_in = 6'd5;
    tick();
    checks++;
    if (bus.coin_reject !== 1'b1 || bus.credit !== 6'd10) begin
      errors++;
      $display("FAIL cancel_coin: reject/credit got %b/%0d expected 1/10",
               bus.coin_reject, bus.credit);
    end
    tick();
    checks++;
    if (bus.change_valid !== 1'b1 || bus.coin_out !== 6'd10 || bus.product_valid !== 1'b0) begin
      errors++;
      $display("FAIL cancel_refund: cv/co/pv got %b/%0d/%b expected 1/10/0",
               bus.change_valid, bus.coin_out, bus.product_valid);
    end
    checks++;
    if (bus.credit !== 6'd0) begin
      errors++;
      $display("FAIL cancel_credit: got %0d expected 0", bus.credit);
    end
  endtask

  task automatic test_timeout();
    int seen_at;
    logic [5:0] amount;
    seen_at = -1;
    amount  = '0;
    coin(5);
    for (int i = 1; i <= 40 && seen_at < 0; i++) begin
      tick();
      if (bus.change_valid === 1'b1) begin
        seen_at = i;
        amount  = bus.coin_out;
      end
    end
    // Entry at the coin edge, 16 idle cycles in COLLECT, one REFUND cycle.
    checks++;
    if (seen_at != 17 || amount !== 6'd5) begin
      errors++;
      $display("FAIL timeout_refund: cycle/amount got %0d/%0d expected 17/5", seen_at, amount);
    end
  endtask

  task automatic test_sold_out();
    logic pv, cv;
    logic [1:0] po;
    logic [5:0] co;
    for (int k = 0; k < 3; k++) begin
      buy(1, 10, pv, po, cv, co);
      checks++;
      if (pv !== 1'b1 || po !== 2'd1 || cv !== 1'b0) begin
        errors++;
        $display("FAIL stock_buy%0d: pv/po/cv got %b/%0d/%b expected 1/1/0", k, pv, po, cv);
      end
      tick();
    end
    coin(10);
    sel(1);
    checks++;
    if (bus.sold_out !== 1'b1) begin
      errors++;
      $display("FAIL sold_out_pulse: got %b expected 1", bus.sold_out);
    end
    tick();
    tick();
    checks++;
    if (bus.product_valid !== 1'b0 || bus.sold_out !== 1'b0 || bus.credit !== 6'd10) begin
      errors++;
      $display("FAIL sold_out_novend: pv/so/credit got %b/%b/%0d expected 0/0/10",
               bus.product_valid, bus.sold_out, bus.credit);
    end
    bus.cancel = 1'b1;
    tick();
    tick();
    bus.restock   = 1'b1;
    bus.selection = 2'd1;
    tick();
    buy(1, 10, pv, po, cv, co);
    checks++;
    if (pv !== 1'b1 || po !== 2'd1) begin
      errors++;
      $display("FAIL restock_buy: pv/po got %b/%0d expected 1/1", pv, po);
    end
    tick();
  endtask

  task automatic test_reset_mid();
    logic pv, cv;
    logic [1:0] po;
    logic [5:0] co;
    coin(10);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checks++;
    if ({bus.product_valid, bus.change_valid, bus.coin_reject, bus.sold_out} !== 4'b0000 ||
        bus.credit !== 6'd0 || bus.coin_out !== 6'd0 || bus.product_out !== 2'd0) begin
      errors++;
      $display("FAIL reset_mid: pulses/credit got %b/%0d expected 0000/0",
               {bus.product_valid, bus.change_valid, bus.coin_reject, bus.sold_out}, bus.credit);
    end
    tick();
    checks++;
    if (bus.change_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_norefund: change_valid got %b expected 0", bus.change_valid);
    end
    // Product 0 was bought once earlier; three more buys only succeed if stock reloaded.
    for (int k = 0; k < 3; k++) begin
      buy(0, 5, pv, po, cv, co);
      checks++;
      if (pv !== 1'b1 || po !== 2'd0) begin
        errors++;
        $display("FAIL reset_stock%0d: pv/po got %b/%0d expected 1/0", k, pv, po);
      end
      tick();
    end
  endtask

  initial begin
    checks         = 0;
    errors         = 0;
    reset          = 1'b1;
    bus.coin_valid = 1'b0;
    bus.coin_in    = '0;
    bus.sel_valid  = 1'b0;
    bus.selection  = '0;
    bus.cancel     = 1'b0;
    bus.restock    = 1'b0;
    test_reset();
    test_simple_vend();
    test_change();
    test_coin_reject();
    test_cancel();
    test_timeout();
    test_sold_out();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
